// File: rtl/traffic_seq_ctl.sv
// traffic_seq_ctl: round-robin multi-phase traffic-light sequencer with prescaled one-second timing
module traffic_seq_ctl #(
  parameter int NPH   = 3,
  parameter int UCY   = 1000,
  parameter int GRN_T = 10,
  parameter int YEL_T = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    adv,
  input  logic                    hold,
  output logic [NPH-1:0]          go,
  output logic [NPH-1:0]          yel,
  output logic [$clog2(NPH)-1:0]  phase,
  output logic                    tick,
  output logic                    adv_ack
);
  localparam int PW = UCY > 1 ? $clog2(UCY) : 1;
  localparam int MT = GRN_T > YEL_T ? GRN_T : YEL_T;
  localparam int SW = MT > 1 ? $clog2(MT) : 1;
  localparam int HW = $clog2(NPH);
  typedef enum logic {GREEN, YELLOW} mode_e;
  mode_e         mode_q, mode_d;
  logic [HW-1:0] phase_q, phase_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] sec_q, sec_d;
  logic          adv_ack_q, adv_ack_d;
  logic          term;
  assign tick    = pre_q == PW'(UCY - 1) && !hold;
  assign term    = tick && sec_q == (mode_q == GREEN ? SW'(GRN_T - 1) : SW'(YEL_T - 1));
  assign phase   = phase_q;
  assign go      = {{(NPH-1){1'b0}}, 1'b1} << phase_q;
  assign yel     = mode_q == YELLOW ? go : '0;
  assign adv_ack = adv_ack_q;
  always_comb begin
    mode_d    = mode_q;
    phase_d   = phase_q;
    pre_d     = hold ? pre_q : tick ? '0 : pre_q + 1'b1;
    sec_d     = tick ? sec_q + 1'b1 : sec_q;
    adv_ack_d = 1'b0;
    if (int'(phase_q) >= NPH) begin
      mode_d  = GREEN;
      phase_d = '0;
      pre_d   = '0;
      sec_d   = '0;
    end else if (mode_q == GREEN && (adv || term)) begin
      mode_d    = YELLOW;
      pre_d     = '0;
      sec_d     = '0;
      adv_ack_d = adv;
    end else if (term) begin
      mode_d  = GREEN;
      phase_d = phase_q == HW'(NPH - 1) ? '0 : phase_q + 1'b1;
      pre_d   = '0;
      sec_d   = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q    <= GREEN;
      phase_q   <= '0;
      pre_q     <= '0;
      sec_q     <= '0;
      adv_ack_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      phase_q   <= phase_d;
      pre_q     <= pre_d;
      sec_q     <= sec_d;
      adv_ack_q <= adv_ack_d;
    end
  end
endmodule

// File: tb/tb_traffic_seq_ctl.sv
// tb_traffic_seq_ctl: random stimulus on two configurations checked against an elapsed-time model
module tb_traffic_seq_ctl;
  logic       clk = 1'b0;
  logic [1:0] rst, adv, hold;
  logic [2:0] go0, yel0;
  logic [1:0] phase0;
  logic [1:0] go1, yel1;
  logic       phase1;
  logic [1:0] tick, ack;
  int n_tests = 0;
  int n_fail  = 0;
  int p_n[2] = '{3, 2};
  int p_u[2] = '{4, 1};
  int p_g[2] = '{3, 1};
  int p_y[2] = '{2, 1};
  int m_ph[2], m_y[2], m_el[2], m_ack[2];
  always #5 clk = ~clk;
  traffic_seq_ctl #(.NPH(3), .UCY(4), .GRN_T(3), .YEL_T(2)) u_a (
    .clk(clk), .rst(rst[0]), .adv(adv[0]), .hold(hold[0]),
    .go(go0), .yel(yel0), .phase(phase0), .tick(tick[0]), .adv_ack(ack[0])
  );
  traffic_seq_ctl #(.NPH(2), .UCY(1), .GRN_T(1), .YEL_T(1)) u_b (
    .clk(clk), .rst(rst[1]), .adv(adv[1]), .hold(hold[1]),
    .go(go1), .yel(yel1), .phase(phase1), .tick(tick[1]), .adv_ack(ack[1])
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // el counts un-held cycles spent in the current green or yellow interval
  task automatic step(input int i);
    m_ack[i] = 0;
    if (!rst[i]) begin
      m_ph[i] = 0; m_y[i] = 0; m_el[i] = 0;
    end else if (!m_y[i] && adv[i]) begin
      m_y[i] = 1; m_el[i] = 0; m_ack[i] = 1;
    end else if (!hold[i]) begin
      m_el[i]++;
      if (m_el[i] == (m_y[i] ? p_y[i] : p_g[i]) * p_u[i]) begin
        m_el[i] = 0;
        if (m_y[i]) begin
          m_y[i]  = 0;
          m_ph[i] = (m_ph[i] + 1) % p_n[i];
        end else m_y[i] = 1;
      end
    end
  endtask
  task automatic check(input int i);
    logic [31:0] g, y, ph, t, a, eg, ey, et;
    g  = i == 0 ? 32'(go0) : 32'(go1);
    y  = i == 0 ? 32'(yel0) : 32'(yel1);
    ph = i == 0 ? 32'(phase0) : 32'(phase1);
    t  = 32'(tick[i]);
    a  = 32'(ack[i]);
    eg = 32'(1) << m_ph[i];
    ey = m_y[i] ? eg : 32'(0);
    et = 32'(!hold[i] && (m_el[i] % p_u[i] == p_u[i] - 1));
    chk($sformatf("u%0d go", i), g, eg);
    chk($sformatf("u%0d yel", i), y, ey);
    chk($sformatf("u%0d phase", i), ph, 32'(m_ph[i]));
    chk($sformatf("u%0d tick", i), t, et);
    chk($sformatf("u%0d adv_ack", i), a, 32'(m_ack[i]));
  endtask
  initial begin
    rst = 2'b00; adv = 2'b00; hold = 2'b00;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      step(0);
      step(1);
      @(negedge clk);
      check(0);
      check(1);
      for (int i = 0; i < 2; i++) begin
        if (c < 150) begin
          rst[i] = 1'b1; adv[i] = 1'b0; hold[i] = 1'b0;
        end else begin
          rst[i] = $urandom_range(299) != 0;
          adv[i] = $urandom_range(24) == 0;
          if ($urandom_range(11) == 0) hold[i] = ~hold[i];
        end
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/traffic_seq_ctl.md
# traffic_seq_ctl

Parametrised multi-phase traffic-light sequencer: the next generation of the three-direction light controller. It cycles NPH approach phases in round-robin order. Each phase has a timed green interval followed by a timed yellow interval. An advance request cuts the current green short, and a hold input freezes all timing. A built-in prescaler turns the system clock into a 1-second tick, and all phase durations are counted in seconds.

## Interface
- NPH, 3: number of phases; legal range 2..16.
- UCY, 1000: clock cycles per second tick; must be ≥1.
- GRN_T, 10: green duration in seconds; must be ≥1.
- YEL_T, 3: yellow duration in seconds; must be ≥1.
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset; synchronous, active-low.
- adv  input  1  advance request; level sampled every clk edge.
- hold  input  1  freeze timing while high.
- go  output  NPH  one-hot "may pass" per phase; high during that phase's green and yellow.
- yel  output  NPH  one-hot; high only during that phase's yellow.
- phase  output  $clog2(NPH)  index of the active phase.
- tick  output  1  one-cycle pulse at each 1-second boundary.
- adv_ack  output  1  one-cycle pulse when an advance is accepted.

## Operation
- The state is {phase index, mode ∈ {GREEN, YELLOW}, prescaler pre, second counter sec}.
- Widths:
  - pre is $clog2(UCY) bits, minimum 1.
  - sec is $clog2(max(GRN_T,YEL_T)) bits, minimum 1.
  - Both counters are unsigned and never wrap past their terminal value.
- Reset (rst=0 at an edge) gives:
  - phase=0, mode=GREEN, pre=0, sec=0.
  - go=1 (bit 0 only), yel=0, tick=0, adv_ack=0.
- Outputs:
  - go, yel and phase are decoded from registered state.
  - tick = (pre==UCY-1) && !hold.
  - adv_ack is registered.
- Prescaler: when hold=0, pre increments each cycle and wraps from UCY-1 to 0.
- Second counter: sec increments on tick.
- Terminal count: in mode M with duration T (GRN_T or YEL_T), a tick with sec==T-1 triggers the transition and clears pre and sec.
- Transition GREEN→YELLOW: same phase; yel[phase] rises and go stays high.
- Transition YELLOW→GREEN: phase advances (phase+1, wrapping NPH-1→0); the old go bit falls and the new go bit rises in the same cycle, so no all-red gap and no overlap.
- Advance request:
  - adv=1 sampled in GREEN forces the transition to YELLOW at that edge.
  - pre and sec are cleared and adv_ack pulses.
  - adv is accepted regardless of hold.
- adv while in YELLOW is ignored, with no ack. It is not stored, so a requester must hold or re-pulse it.
- Simultaneous adv and green terminal tick: a single transition to YELLOW is made, and adv_ack still pulses.
- hold=1:
  - pre and sec are frozen and tick is suppressed.
  - Mode and phase do not change except via adv.
  - On release, timing resumes from the frozen values.
- Every state has exactly one go bit set. The illegal encodings go=0 and multiple bits set are unreachable. Any out-of-range phase value (NPH not a power of 2) recovers to phase 0 GREEN on the next edge.

## Timing
- Reset has priority over everything. rst=0 mid-phase restarts at phase 0 GREEN on that edge.
- Each interval has an exact length (with hold=0 and no adv):
  - Green lasts GRN_T·UCY cycles.
  - Yellow lasts YEL_T·UCY cycles.
  - A full rotation is NPH·(GRN_T+YEL_T)·UCY cycles.
- First transition: the first GREEN→YELLOW change of go/yel is visible in the cycle GRN_T·UCY cycles after the first post-reset edge.
- adv latency: adv high at edge k puts yel high from cycle k+1, with adv_ack high for exactly cycle k+1. The following yellow then lasts a full YEL_T·UCY cycles.
- With UCY=1, tick is high every non-hold cycle.
- No combinational path from adv or hold to go, yel or phase. tick depends combinationally on hold only.

## Test plan
- Reset then free run (NPH=3, UCY=4, GRN_T=3, YEL_T=2), hold=0, adv=0:
  - go=001 for 20 cycles, with yel=001 during the last 8 of them.
  - Then go=010, then go=100, then back to go=001 at cycle 60.
  - tick every 4th cycle.
- adv pulse 5 cycles into phase 0 green:
  - yel=001 next cycle and adv_ack=1 for that one cycle.
  - Yellow holds 8 cycles, then go=010.
- adv during yellow and adv on the exact green terminal tick:
  - The first produces no ack and no change.
  - The second produces one transition and one ack, with yellow still 8 cycles long.
- hold=1 for 10 cycles mid-green (after sec=1, pre=2):
  - Outputs unchanged and tick=0 throughout.
  - Green extends by exactly 10 cycles.
  - adv during hold is still accepted.
- Mid-yellow reset: rst=0 for 1 cycle while in phase 2 yellow gives phase=0, go=001, yel=0, tick=0 next cycle, and a fresh 20-cycle phase 0.
- UCY=1, NPH=2, GRN_T=1, YEL_T=1:
  - go alternates 01/10 every 2 cycles.
  - yel is high on every second cycle.
  - tick stays high.
